// File: rtl/wb_commit_unit.sv
// Write-back commit unit: GPR file, HI/LO pair, LLbit and a retire counter.
// Optional write-through forwarding to all read outputs when WB_BYPASS_EN is defined.
module wb_commit_unit #(
  parameter int CNT_W    = 32,
  parameter int NUM_REGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [4:0]       wb_wd,
  input  logic             wb_wreg,
  input  logic [31:0]      wb_wdata,
  input  logic [31:0]      wb_hi,
  input  logic [31:0]      wb_lo,
  input  logic             wb_whilo,
  input  logic             wb_LLbit_we,
  input  logic             wb_LLbit_value,
  input  logic             re1,
  input  logic [4:0]       raddr1,
  input  logic             re2,
  input  logic [4:0]       raddr2,
  output logic [31:0]      rdata1,
  output logic [31:0]      rdata2,
  output logic [31:0]      hi_o,
  output logic [31:0]      lo_o,
  output logic             LLbit_o,
  output logic [CNT_W-1:0] retire_cnt
);

  logic [31:0]      gpr_q [NUM_REGS];
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             ll_q, ll_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gpr_we;
  logic             commit;

  assign gpr_we = wb_wreg && (wb_wd != 5'd0);
  assign commit = gpr_we || wb_whilo || wb_LLbit_we;

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    ll_d  = ll_q;
    cnt_d = cnt_q;
    if (wb_whilo) begin
      hi_d = wb_hi;
      lo_d = wb_lo;
    end
    // flush outranks a same-cycle LL/SC write
    if (flush) begin
      ll_d = 1'b0;
    end else if (wb_LLbit_we) begin
      ll_d = wb_LLbit_value;
    end
    if (commit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        gpr_q[i] <= '0;
      end
      hi_q  <= '0;
      lo_q  <= '0;
      ll_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (gpr_we) begin
        gpr_q[wb_wd] <= wb_wdata;
      end
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      ll_q  <= ll_d;
      cnt_q <= cnt_d;
    end
  end

  function automatic logic [31:0] read_port(input logic en, input logic [4:0] addr);
    logic [31:0] val;
    val = '0;
    if (rst && en && (addr != 5'd0)) begin
`ifdef WB_BYPASS_EN
      if (wb_wreg && (addr == wb_wd)) begin
        val = wb_wdata;
      end else begin
        val = gpr_q[addr];
      end
`else
      val = gpr_q[addr];
`endif
    end
    return val;
  endfunction

  always_comb begin
    rdata1 = read_port(re1, raddr1);
    rdata2 = read_port(re2, raddr2);
  end

  always_comb begin
    hi_o    = '0;
    lo_o    = '0;
    LLbit_o = 1'b0;
    if (rst) begin
`ifdef WB_BYPASS_EN
      hi_o    = wb_whilo ? wb_hi : hi_q;
      lo_o    = wb_whilo ? wb_lo : lo_q;
      LLbit_o = flush ? 1'b0 : (wb_LLbit_we ? wb_LLbit_value : ll_q);
`else
      hi_o    = hi_q;
      lo_o    = lo_q;
      LLbit_o = ll_q;
`endif
    end
  end

  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Scoreboard bench for wb_commit_unit: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_wb_commit_unit;
  localparam int CNT_W = 4;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [4:0]       wb_wd;
  logic             wb_wreg;
  logic [31:0]      wb_wdata;
  logic [31:0]      wb_hi;
  logic [31:0]      wb_lo;
  logic             wb_whilo;
  logic             wb_LLbit_we;
  logic             wb_LLbit_value;
  logic             re1;
  logic [4:0]       raddr1;
  logic             re2;
  logic [4:0]       raddr2;
  logic [31:0]      rdata1;
  logic [31:0]      rdata2;
  logic [31:0]      hi_o;
  logic [31:0]      lo_o;
  logic             LLbit_o;
  logic [CNT_W-1:0] retire_cnt;

  wb_commit_unit #(.CNT_W(CNT_W), .NUM_REGS(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
    .wb_LLbit_we(wb_LLbit_we), .wb_LLbit_value(wb_LLbit_value),
    .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2), .hi_o(hi_o), .lo_o(lo_o),
    .LLbit_o(LLbit_o), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef enum int {S_RD1, S_RD2, S_HI, S_LO, S_LL, S_CNT} sel_e;
  typedef struct {
    int          cyc;
    sel_e        sel;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sample(input sel_e s);
    case (s)
      S_RD1:   return rdata1;
      S_RD2:   return rdata2;
      S_HI:    return hi_o;
      S_LO:    return lo_o;
      S_LL:    return {31'd0, LLbit_o};
      default: return {{(32-CNT_W){1'b0}}, retire_cnt};
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      chk_t e;
      logic [31:0] act;
      e = sb.pop_front();
      act = sample(e.sel);
      n_vec++;
      if (act !== e.exp) begin
        n_err++;
        $display("FAIL %s (cycle %0d): got %h, expected %h", e.name, cyc, act, e.exp);
      end
    end
  end

  task automatic expect_val(input sel_e s, input logic [31:0] v, input string nm);
    chk_t e;
    e.cyc = cyc; e.sel = s; e.exp = v; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_wb();
    flush = 0; wb_wreg = 0; wb_wd = '0; wb_wdata = '0; wb_whilo = 0;
    wb_hi = '0; wb_lo = '0; wb_LLbit_we = 0; wb_LLbit_value = 0;
  endtask

  initial begin
    idle_wb();
    re1 = 0; raddr1 = '0; re2 = 0; raddr2 = '0;

    // 1. reset held two cycles while every write path is active
    rst = 0;
    wb_wreg = 1; wb_wd = 5'd5; wb_wdata = 32'hDEAD_BEEF;
    wb_whilo = 1; wb_hi = 32'hFFFF_FFFF; wb_lo = 32'hEEEE_EEEE;
    wb_LLbit_we = 1; wb_LLbit_value = 1;
    re1 = 1; raddr1 = 5'd5;
    for (int k = 0; k < 2; k++) begin
      step();
      expect_val(S_RD1, 32'h0, "rst_rdata1");
      expect_val(S_HI,  32'h0, "rst_hi");
      expect_val(S_LO,  32'h0, "rst_lo");
      expect_val(S_LL,  32'h0, "rst_llbit");
      expect_val(S_CNT, 32'h0, "rst_cnt");
    end
    step();
    rst = 1; idle_wb();
    expect_val(S_RD1, 32'h0, "post_rst_gpr5");
    expect_val(S_CNT, 32'h0, "post_rst_cnt");

    // 2. write $7, read on both ports next cycle, then write $0
    step();
    wb_wreg = 1; wb_wd = 5'd7; wb_wdata = 32'h1234_5678;
    expect_val(S_CNT, 32'h0, "cnt_before_w7");
    step();
    wb_wd = 5'd0; wb_wdata = 32'hFFFF_FFFF;
    re1 = 1; raddr1 = 5'd7; re2 = 1; raddr2 = 5'd7;
    expect_val(S_RD1, 32'h1234_5678, "rd1_r7");
    expect_val(S_RD2, 32'h1234_5678, "rd2_r7");
    expect_val(S_CNT, 32'h1, "cnt_after_w7");
    step();
    idle_wb();
    raddr1 = 5'd0;
    expect_val(S_RD1, 32'h0, "rd_r0");
    expect_val(S_RD2, 32'h1234_5678, "rd2_r7_again");
    expect_val(S_CNT, 32'h1, "cnt_r0_write_ignored");
    step();
    re2 = 0;
    expect_val(S_RD2, 32'h0, "rd2_disabled");

    // 3. same-cycle read of the register being written
    step();
    wb_wreg = 1; wb_wd = 5'd9; wb_wdata = 32'hA5A5_A5A5;
    re1 = 1; raddr1 = 5'd9; re2 = 1; raddr2 = 5'd9;
    expect_val(S_RD1, BYP ? 32'hA5A5_A5A5 : 32'h0, "rd1_same_cycle");
    expect_val(S_RD2, BYP ? 32'hA5A5_A5A5 : 32'h0, "rd2_same_cycle");
    step();
    idle_wb();
    expect_val(S_RD1, 32'hA5A5_A5A5, "rd1_next_cycle");
    expect_val(S_CNT, 32'h2, "cnt_after_w9");

    // 4. HI/LO write, then LLbit with flush priority
    step();
    wb_whilo = 1; wb_hi = 32'h1; wb_lo = 32'h2;
    expect_val(S_HI, BYP ? 32'h1 : 32'h0, "hi_same_cycle");
    expect_val(S_LO, BYP ? 32'h2 : 32'h0, "lo_same_cycle");
    step();
    idle_wb();
    flush = 1; wb_LLbit_we = 1; wb_LLbit_value = 1;
    expect_val(S_HI, 32'h1, "hi_committed");
    expect_val(S_LO, 32'h2, "lo_committed");
    expect_val(S_LL, 32'h0, "ll_flush_wins_same");
    expect_val(S_CNT, 32'h3, "cnt_after_hilo");
    step();
    flush = 0;
    expect_val(S_LL, BYP ? 32'h1 : 32'h0, "ll_write_same_cycle");
    expect_val(S_CNT, 32'h4, "cnt_ll_with_flush");
    step();
    idle_wb();
    expect_val(S_LL, 32'h1, "ll_set");
    expect_val(S_CNT, 32'h5, "cnt_after_ll");
    step();
    flush = 1;
    expect_val(S_LL, BYP ? 32'h0 : 32'h1, "ll_flush_same_cycle");
    step();
    flush = 0;
    expect_val(S_LL, 32'h0, "ll_cleared");
    expect_val(S_CNT, 32'h5, "cnt_flush_no_commit");

    // 5. mid-stream reset drops a write, then 17 commits wrap the 4-bit counter
    step();
    rst = 0; wb_wreg = 1; wb_wd = 5'd12; wb_wdata = 32'hCAFE_0001;
    step();
    rst = 1; idle_wb();
    re1 = 1; raddr1 = 5'd12; re2 = 1; raddr2 = 5'd9;
    expect_val(S_RD1, 32'h0, "rst_drop_w12");
    expect_val(S_RD2, 32'h0, "rst_clear_r9");
    expect_val(S_HI,  32'h0, "rst_clear_hi");
    expect_val(S_CNT, 32'h0, "rst_clear_cnt");
    for (int i = 0; i < 17; i++) begin
      step();
      wb_wreg = 1; wb_wd = 5'd3; wb_wdata = 32'h100 + i;
      expect_val(S_CNT, i % 16, "cnt_wrap_seq");
    end
    step();
    idle_wb();
    raddr1 = 5'd3;
    expect_val(S_CNT, 32'h1, "cnt_wrapped");
    expect_val(S_RD1, 32'h110, "last_w3");
    for (int i = 0; i < 3; i++) begin
      step();
      expect_val(S_CNT, 32'h1, "cnt_idle_hold");
    end

    step();
    step();
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end of stimulus, expected finish");
    $fatal(1, "timeout");
  end

endmodule
